dmac_ahb_master_if: RTL
=======================

Name: dmac_ahb_master_if

Overview:
- Downstream neighbour of the DMA channel. Takes the channel's master request (HTrans, write, MAddress, MWData, MWStrb, HSize) and drives a single AHB-Lite master port.
- Owns the address-phase to data-phase pipeline, write-data alignment, wait-state propagation and the two-cycle ERROR response.
- Returns readyIn, M_HResp and R_Data to the channel.
- Sits between the channel and the system bus (or the bus arbiter).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32, since strobes are 4 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ch_HTrans  in  2  channel transfer type (00 IDLE, 10 NONSEQ, 11 SEQ)
- ch_write  in  1  channel direction, 1 = write
- ch_MAddress  in  ADDR_W  channel address
- ch_MWData  in  DATA_W  channel write data, valid with the address phase
- ch_MWStrb  in  4  channel byte strobes
- ch_HSize  in  2  transfer size (00 byte, 01 half, 10 word)
- readyIn  out  1  transfer-accept/ready to the channel
- M_HResp  out  2  response to the channel (00 OKAY, 01 ERROR)
- R_Data  out  DATA_W  read data to the channel
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  AHB transfer type
- HWRITE  out  1  AHB direction
- HSIZE  out  3  AHB size, {1'b0, ch_HSize}
- HBURST  out  3  constant 3'b001 (INCR)
- HWDATA  out  DATA_W  AHB write data (data phase)
- HWSTRB  out  4  AHB write strobes (data phase)
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response, 1 = ERROR
- HRDATA  in  DATA_W  AHB read data
- busy  out  1  data phase outstanding

Behaviour:
- Reset values:
  - State registers: FSM = ACTIVE, dp_valid = 0, dp_write = 0.
  - Data registers: HWDATA = 0, HWSTRB = 0.
  - Outputs: HTRANS = IDLE, readyIn = 1, M_HResp = OKAY, R_Data = 0, busy = 0.
- Reset mid-transfer abandons the data phase silently; no response is sent to the channel.
- Address phase is combinational pass-through:
  - HADDR = ch_MAddress, HWRITE = ch_write, HSIZE = {0, ch_HSize}.
  - HTRANS = ch_HTrans, except in ERR1, ERR2 and ERR_HOLD, where HTRANS is forced to IDLE.
- The channel holds all inputs stable while readyIn = 0. The block relies on this and does not re-register the address.
- Address acceptance: when HREADY = 1 and HTRANS is NONSEQ/SEQ, the following are registered:
  - dp_valid <= 1, dp_write <= ch_write, dp_addr <= ch_MAddress.
  - If ch_write: HWDATA <= ch_MWData and HWSTRB <= ch_MWStrb; otherwise HWSTRB <= 0.
  - With HREADY = 1 and HTRANS = IDLE: dp_valid <= 0.
  - With HREADY = 0: all data-phase registers hold.
- Latency: write data appears on HWDATA exactly one cycle after address acceptance and is held through wait states.
- Read path: R_Data <= HRDATA, registered when dp_valid, !dp_write, HREADY = 1 and HRESP = 0. R_Data holds otherwise.
- readyIn = HREADY in ACTIVE, and 0 in ERR1, ERR2 and ERR_HOLD. busy = dp_valid.
- FSM states:
  - ACTIVE: normal pipelining.
    - dp_valid, HRESP = 1, HREADY = 0 -> ERR1. HTRANS is forced to IDLE combinationally in this same cycle, cancelling the pending address.
    - HRESP = 1 with HREADY = 1 is an AHB protocol violation; it is treated as ERR2 directly.
  - ERR1: HTRANS = IDLE.
    - HREADY = 1 (second error cycle) -> ERR2, with M_HResp <= ERROR for one cycle and dp_valid <= 0.
    - Otherwise remain in ERR1.
  - ERR2: one cycle. M_HResp = ERROR is visible to the channel here.
    - -> ERR_HOLD, with M_HResp <= OKAY.
  - ERR_HOLD: HTRANS = IDLE, readyIn = 0.
    - Exit to ACTIVE when ch_HTrans == IDLE, i.e. the channel has aborted or restarted.
- A cancelled address in ERR1 is never issued. A new NONSEQ from the channel after ERR_HOLD starts a fresh transfer.
- Back-to-back: a SEQ address may be accepted in the same cycle as the previous data phase completes (full AHB pipelining). No bubble is inserted.
- HREADY low with no data phase outstanding is legal (another master's data phase). The address is simply held.

Decomposition:
- Package dmac_pkg holds:
  - htrans_t (IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11).
  - hresp constants OKAY = 2'b00, ERROR = 2'b01.
  - HBURST_INCR = 3'b001.
  - the error-FSM enum (ACTIVE, ERR1, ERR2, ERR_HOLD).
- One sub-module is natural: dmac_ahb_dphase_reg (data-phase capture of dp_valid, dp_write, dp_addr, HWDATA and HWSTRB, with HREADY-qualified enable).
- The FSM and output muxing stay in the top.

Test Plan:
- Single word write, HREADY = 1. Stimulus: NONSEQ, addr 0x1000, data 0xDEADBEEF, strb 4'hF. Response: HADDR = 0x1000 in cycle 0; HWDATA = 0xDEADBEEF, HWSTRB = 4'hF in cycle 1; busy = 1 in cycle 1 only.
- 4-beat read burst, 0x2000 to 0x200C, with 2 wait states on beat 2. Response: readyIn low for 2 cycles; HADDR holds 0x2008; R_Data updates to the HRDATA values 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Write burst with HREADY low for 3 cycles on beat 1. Response: HWDATA holds beat-1 data for all 4 cycles; beat-2 data appears the cycle after HREADY returns.
- ERROR on beat 2 of a read. Stimulus: HRESP = 1 / HREADY = 0, then HRESP = 1 / HREADY = 1. Response: HTRANS = IDLE in both cycles; M_HResp = 01 for one cycle; readyIn = 0 until ch_HTrans = IDLE; then ACTIVE.
- Reset asserted mid data phase of a write (dp_valid = 1). Response: immediately HTRANS = IDLE (given ch_HTrans = IDLE), busy = 0, HWSTRB = 0, M_HResp = 00; no spurious response after release.
- Byte write, ch_HSize = 00, addr 0x3003, strb 4'h8. Response: HSIZE = 000; HWSTRB = 4'h8 in the data phase; HBURST = 001 throughout.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared AHB encodings and the error-response FSM states for the DMA master interface.
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;

  localparam logic [2:0] HBURST_INCR = 3'b001;

  typedef enum logic [1:0] {
    ACTIVE,
    ERR1,
    ERR2,
    ERR_HOLD
  } err_state_t;

  // NONSEQ and SEQ both carry bit 1; IDLE and BUSY do not.
  function automatic logic is_xfer(logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/dmac_ahb_dphase_reg.sv
// Data-phase capture: latches the accepted address-phase attributes and write data
// so they line up with the AHB data phase; everything holds while HREADY is low.
module dmac_ahb_dphase_reg
  import dmac_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic              dp_valid,
  output logic              dp_write,
  output logic [ADDR_W-1:0] dp_addr,
  output logic [DATA_W-1:0] hwdata,
  output logic [3:0]        hwstrb
);

  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [ADDR_W-1:0] dp_addr_q,  dp_addr_d;
  logic [DATA_W-1:0] hwdata_q,   hwdata_d;
  logic [3:0]        hwstrb_q,   hwstrb_d;

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    hwdata_d   = hwdata_q;
    hwstrb_d   = hwstrb_q;
    if (hready) begin
      if (is_xfer(htrans)) begin
        dp_valid_d = 1'b1;
        dp_write_d = write;
        dp_addr_d  = addr;
        if (write) begin
          hwdata_d = wdata;
          hwstrb_d = wstrb;
        end else begin
          hwstrb_d = '0;
        end
      end else begin
        dp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      hwdata_q   <= '0;
      hwstrb_q   <= '0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      hwdata_q   <= hwdata_d;
      hwstrb_q   <= hwstrb_d;
    end
  end

  assign dp_valid = dp_valid_q;
  assign dp_write = dp_write_q;
  assign dp_addr  = dp_addr_q;
  assign hwdata   = hwdata_q;
  assign hwstrb   = hwstrb_q;

endmodule

// File: rtl/dmac_ahb_master_if.sv
// AHB-Lite master port for the DMA channel: combinational address phase, registered
// data phase, read-data capture and the two-cycle ERROR response handling.
module dmac_ahb_master_if
  import dmac_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ch_HTrans,
  input  logic              ch_write,
  input  logic [ADDR_W-1:0] ch_MAddress,
  input  logic [DATA_W-1:0] ch_MWData,
  input  logic [3:0]        ch_MWStrb,
  input  logic [1:0]        ch_HSize,
  output logic              readyIn,
  output logic [1:0]        M_HResp,
  output logic [DATA_W-1:0] R_Data,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  output logic [3:0]        HWSTRB,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              busy
);

  err_state_t        state_q, state_d;
  logic [1:0]        m_hresp_q, m_hresp_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              trans_kill;

  logic              dp_valid;
  logic              dp_write;
  logic [ADDR_W-1:0] dp_addr;

  dmac_ahb_dphase_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dphase (
    .clk      (clk),
    .rst      (rst),
    .hready   (HREADY),
    .htrans   (HTRANS),
    .write    (ch_write),
    .addr     (ch_MAddress),
    .wdata    (ch_MWData),
    .wstrb    (ch_MWStrb),
    .dp_valid (dp_valid),
    .dp_write (dp_write),
    .dp_addr  (dp_addr),
    .hwdata   (HWDATA),
    .hwstrb   (HWSTRB)
  );

  always_comb begin
    state_d    = state_q;
    m_hresp_d  = m_hresp_q;
    trans_kill = 1'b0;
    readyIn    = HREADY;
    case (state_q)
      ACTIVE: begin
        // The first ERROR cycle cancels the pending address in the same cycle.
        if (dp_valid && HRESP) begin
          trans_kill = 1'b1;
          if (HREADY) begin
            state_d   = ERR2;
            m_hresp_d = ERROR;
          end else begin
            state_d = ERR1;
          end
        end
      end
      ERR1: begin
        trans_kill = 1'b1;
        readyIn    = 1'b0;
        if (HREADY) begin
          state_d   = ERR2;
          m_hresp_d = ERROR;
        end
      end
      ERR2: begin
        trans_kill = 1'b1;
        readyIn    = 1'b0;
        state_d    = ERR_HOLD;
        m_hresp_d  = OKAY;
      end
      ERR_HOLD: begin
        trans_kill = 1'b1;
        readyIn    = 1'b0;
        if (ch_HTrans == IDLE) state_d = ACTIVE;
      end
      default: begin
        state_d = ACTIVE;
      end
    endcase
  end

  always_comb begin
    r_data_d = r_data_q;
    if (dp_valid && !dp_write && HREADY && !HRESP) r_data_d = HRDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACTIVE;
      m_hresp_q <= OKAY;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_hresp_q <= m_hresp_d;
      r_data_q  <= r_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dp_valid) assert (!$isunknown(dp_addr));
  end

  assign HADDR   = ch_MAddress;
  assign HWRITE  = ch_write;
  assign HSIZE   = {1'b0, ch_HSize};
  assign HBURST  = HBURST_INCR;
  assign HTRANS  = trans_kill ? IDLE : ch_HTrans;
  assign M_HResp = m_hresp_q;
  assign R_Data  = r_data_q;
  assign busy    = dp_valid;

endmodule
